twobit_run_controller: RTL

Run controller for the 2-bit computer. Owns the 4-word × 2-bit program store that feeds the computer's two RAM multiplexers (X0–X3, Y0–Y3). Sequences the computer through load, reset, run/single-step and halt, and gates its clock. Provides a cycle budget so a program that never reaches HLT is stopped and flagged.

---
 rtl/twobit_ctrl_pkg.sv | 20 ++
 rtl/twobit_prog_mem.sv | 38 +++
 rtl/twobit_run_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/twobit_ctrl_pkg.sv
// Shared types and constants for the 2-bit computer run controller.
package twobit_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_PSTEP = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  // Instruction encodings {D1,D0} held in the program store.
  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

endpackage

// File: rtl/twobit_prog_mem.sv
// 4-word x 2-bit program store feeding the core's X/Y RAM multiplexers.
// Bit i of o_prog_lsb is D0 of word i, bit i of o_prog_msb is D1 of word i.
module twobit_prog_mem
  import twobit_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_addr,
  input  logic [1:0] i_wr_data,
  output logic [3:0] o_prog_lsb,
  output logic [3:0] o_prog_msb
);

  logic [1:0] r_mem [4];

  // Storage update: clear to all-INC on reset, otherwise write the addressed word.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= OP_INC;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Flatten the words into the two multiplexer select buses.
  always_comb begin
    o_prog_lsb = 4'b0000;
    o_prog_msb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      o_prog_lsb[i] = r_mem[i][0];
      o_prog_msb[i] = r_mem[i][1];
    end
  end

endmodule

// File: rtl/twobit_run_controller.sv
// Run controller for the 2-bit computer: program loading, core reset,
// run / single-step sequencing, clock gating and a run-cycle budget.
module twobit_run_controller
  import twobit_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES   = 64,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [1:0] wr_data,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  input  logic       halt_in,
  output logic [3:0] prog_lsb,
  output logic [3:0] prog_msb,
  output logic       core_reset,
  output logic       core_run,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] cycle_count
);

  localparam logic [7:0] LP_MAX      = 8'(MAX_CYCLES);
  localparam logic [3:0] LP_RST_LAST = 4'(RESET_CYCLES - 1);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  logic [3:0]  r_rst_cnt;
  logic [3:0]  w_rst_cnt_nxt;
  logic        r_step_mode;
  logic        w_step_mode_nxt;
  logic [7:0]  r_cycle_count;
  logic [7:0]  w_cycle_count_nxt;
  logic [7:0]  w_cycle_inc;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic        r_wr_ready;
  logic        r_core_reset;
  logic        r_core_run;
  logic        r_busy;
  logic        r_done;
  logic        w_wr_en;

  assign w_cycle_inc = r_cycle_count + 8'd1;
  // Writes are only honoured while the registered ready says so (IDLE/DONE).
  assign w_wr_en     = wr_valid & r_wr_ready;

  twobit_prog_mem u_prog_mem (
    .i_clk      (CLK),
    .i_srst     (Reset),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_prog_lsb (prog_lsb),
    .o_prog_msb (prog_msb)
  );

  // Next-state, reset-hold counter, cycle budget and timeout decisions.
  always_comb begin
    w_state_nxt       = r_state;
    w_rst_cnt_nxt     = r_rst_cnt;
    w_step_mode_nxt   = r_step_mode;
    w_cycle_count_nxt = r_cycle_count;
    w_timeout_nxt     = r_timeout;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt       = ST_CRST;
          w_rst_cnt_nxt     = 4'd0;
          w_step_mode_nxt   = step_mode;
          w_cycle_count_nxt = 8'd0;
          w_timeout_nxt     = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CRST: begin
        if (r_rst_cnt == LP_RST_LAST) begin
          w_state_nxt = r_step_mode ? ST_PAUSE : ST_RUN;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 4'd1;
        end
      end
      ST_RUN: begin
        // Halt wins over the budget: no increment, no timeout.
        if (halt_in) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cycle_count_nxt = w_cycle_inc;
          if (w_cycle_inc == LP_MAX) begin
            w_state_nxt   = ST_DONE;
            w_timeout_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_PAUSE: begin
        if (halt_in) begin
          w_state_nxt = ST_DONE;
        end else if (step) begin
          w_state_nxt = ST_PSTEP;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PSTEP: begin
        w_cycle_count_nxt = w_cycle_inc;
        if (w_cycle_inc == LP_MAX) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus counters; outputs are decoded from the next state so
  // they are registered yet aligned with the state they describe.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_rst_cnt     <= 4'd0;
      r_step_mode   <= 1'b0;
      r_cycle_count <= 8'd0;
      r_timeout     <= 1'b0;
      r_wr_ready    <= 1'b1;
      r_core_reset  <= 1'b1;
      r_core_run    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rst_cnt     <= w_rst_cnt_nxt;
      r_step_mode   <= w_step_mode_nxt;
      r_cycle_count <= w_cycle_count_nxt;
      r_timeout     <= w_timeout_nxt;
      r_wr_ready    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
      r_core_reset  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CRST);
      r_core_run    <= (w_state_nxt == ST_RUN)  || (w_state_nxt == ST_PSTEP);
      r_busy        <= (w_state_nxt == ST_CRST) || (w_state_nxt == ST_RUN) ||
                       (w_state_nxt == ST_PAUSE) || (w_state_nxt == ST_PSTEP);
      r_done        <= (w_state_nxt == ST_DONE);
    end
  end

  assign wr_ready    = r_wr_ready;
  assign core_reset  = r_core_reset;
  assign core_run    = r_core_run;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

endmodule
